// File: rtl/tds_channel_merger.sv
// N-channel TDS frame merger: one block-RAM FIFO per lane, round-robin arbiter, registered valid/ready output.
// Define CH_TIMESTAMP_EN to store a 12-bit timestamp with every frame and expose it on out_ts.
module tds_channel_merger #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 120,
  parameter int FIFO_DEPTH = 512,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1,
  parameter int ID_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk160,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        enable,
  input  logic                     tds_mode,
  input  logic [NUM_CH-1:0]        strip_linked,
  input  logic [NUM_CH-1:0]        pad_linked,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        channel_fifo_s_reset,
  input  logic [NUM_CH-1:0]        data_tran_stop,
  output logic [NUM_CH-1:0]        channel_linked,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [ID_W-1:0]          out_ch,
`ifdef CH_TIMESTAMP_EN
  output logic [11:0]              out_ts,
`endif
  output logic [NUM_CH*CNT_W-1:0]  channel_data_counter,
  output logic [NUM_CH-1:0]        channel_fifo_empty,
  output logic [NUM_CH-1:0]        ch_overflow,
  output logic [NUM_CH*16-1:0]     ch_drop_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

`ifdef CH_TIMESTAMP_EN
  localparam int FW = DATA_W + 12;

  logic [11:0] ts_cnt;

  always_ff @(posedge clk160) begin
    if (!reset) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 12'd1;
  end
`else
  localparam int FW = DATA_W;
`endif

  logic [NUM_CH-1:0]    head_vld;
  logic [NUM_CH-1:0]    eligible;
  logic [NUM_CH-1:0]    pop;
  logic [NUM_CH*FW-1:0] head_flat;
  logic [FW-1:0]        sel_word;
  logic [ID_W-1:0]      last_grant;
  logic [ID_W-1:0]      grant;
  logic [ID_W-1:0]      hi_sel;
  logic [ID_W-1:0]      lo_sel;
  logic                 hi_found;
  logic                 any_elig;
  logic                 load_ok;

  assign channel_linked = tds_mode ? strip_linked : pad_linked;
  assign load_ok        = ~out_valid | out_ready;
  assign eligible       = head_vld & ~channel_fifo_s_reset;

  // Prefer the lowest eligible channel above last_grant, otherwise wrap to the lowest overall.
  always_comb begin
    hi_sel   = '0;
    lo_sel   = '0;
    hi_found = 1'b0;
    any_elig = 1'b0;
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      if (eligible[j]) begin
        lo_sel   = ID_W'(j);
        any_elig = 1'b1;
        if (ID_W'(j) > last_grant) begin
          hi_sel   = ID_W'(j);
          hi_found = 1'b1;
        end
      end
    end
    grant = hi_found ? hi_sel : lo_sel;
  end

  always_comb begin
    sel_word = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (grant == ID_W'(j)) sel_word = head_flat[j*FW +: FW];
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [FW-1:0]    mem [FIFO_DEPTH];
    logic [FW-1:0]    rd_q;
    logic [FW-1:0]    wr_word;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_addr;
    logic [CNT_W-1:0] count;
    logic [15:0]      drops;
    logic             ovf;
    logic             vld;
    logic             wr;
    logic             full;
    logic             push;

    assign pop[i] = load_ok & any_elig & (grant == ID_W'(i));
    assign wr     = ch_valid[i] & enable[i] & channel_linked[i] & ~data_tran_stop[i]
                    & ~channel_fifo_s_reset[i];
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign push    = wr & (~full | pop[i]);
    assign rd_addr = pop[i] ? rd_ptr + PTR_W'(1) : rd_ptr;
`ifdef CH_TIMESTAMP_EN
    assign wr_word = {ts_cnt, ch_data[i*DATA_W +: DATA_W]};
`else
    assign wr_word = ch_data[i*DATA_W +: DATA_W];
`endif

    // Registered read of the next head; a word written this edge is only visible next cycle.
    always_ff @(posedge clk160) begin
      if (push) mem[wr_ptr] <= wr_word;
      rd_q <= mem[rd_addr];
    end

    always_ff @(posedge clk160) begin
      if (!reset || channel_fifo_s_reset[i]) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        drops  <= '0;
        ovf    <= 1'b0;
        vld    <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        rd_ptr <= rd_addr;
        if (push && !pop[i])      count <= count + CNT_W'(1);
        else if (!push && pop[i]) count <= count - CNT_W'(1);
        if (wr && !push) begin
          ovf <= 1'b1;
          if (drops != 16'hFFFF) drops <= drops + 16'd1;
        end
        vld <= (count > CNT_W'(pop[i]));
      end
    end

    assign head_flat[i*FW +: FW]               = rd_q;
    assign head_vld[i]                         = vld;
    assign channel_data_counter[i*CNT_W +: CNT_W] = count;
    assign channel_fifo_empty[i]               = (count == '0);
    assign ch_overflow[i]                      = ovf;
    assign ch_drop_cnt[i*16 +: 16]             = drops;
  end

  always_ff @(posedge clk160) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      last_grant <= '0;
`ifdef CH_TIMESTAMP_EN
      out_ts     <= '0;
`endif
    end else if (load_ok) begin
      if (any_elig) begin
        out_valid  <= 1'b1;
        out_data   <= sel_word[DATA_W-1:0];
        out_ch     <= grant;
        last_grant <= grant;
`ifdef CH_TIMESTAMP_EN
        out_ts     <= sel_word[FW-1:DATA_W];
`endif
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tds_channel_merger.sv
// Scoreboard bench for tds_channel_merger: per-channel expected queues drained by a monitor process.
module tb_tds_channel_merger;

  localparam int NUM_CH     = 4;
  localparam int DATA_W     = 120;
  localparam int FIFO_DEPTH = 16;
  localparam int CNT_W      = 5;
  localparam int ID_W       = 2;

  logic                     clk160;
  logic                     reset;
  logic [NUM_CH-1:0]        enable;
  logic                     tds_mode;
  logic [NUM_CH-1:0]        strip_linked;
  logic [NUM_CH-1:0]        pad_linked;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        channel_fifo_s_reset;
  logic [NUM_CH-1:0]        data_tran_stop;
  logic [NUM_CH-1:0]        channel_linked;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [ID_W-1:0]          out_ch;
`ifdef CH_TIMESTAMP_EN
  logic [11:0]              out_ts;
`endif
  logic [NUM_CH*CNT_W-1:0]  channel_data_counter;
  logic [NUM_CH-1:0]        channel_fifo_empty;
  logic [NUM_CH-1:0]        ch_overflow;
  logic [NUM_CH*16-1:0]     ch_drop_cnt;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] exp_q [NUM_CH][$];
  logic [ID_W-1:0]   exp_ch [$];
`ifdef CH_TIMESTAMP_EN
  int                ts_q [NUM_CH][$];
`endif
  logic [11:0]       tb_ts = '0;

  tds_channel_merger #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk160(clk160), .reset(reset), .enable(enable), .tds_mode(tds_mode),
    .strip_linked(strip_linked), .pad_linked(pad_linked), .ch_valid(ch_valid),
    .ch_data(ch_data), .channel_fifo_s_reset(channel_fifo_s_reset),
    .data_tran_stop(data_tran_stop), .channel_linked(channel_linked),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
`ifdef CH_TIMESTAMP_EN
    .out_ts(out_ts),
`endif
    .channel_data_counter(channel_data_counter), .channel_fifo_empty(channel_fifo_empty),
    .ch_overflow(ch_overflow), .ch_drop_cnt(ch_drop_cnt)
  );

  initial clk160 = 1'b0;
  always #5 clk160 = ~clk160;

  initial begin
    forever begin
      @(posedge clk160);
      tb_ts = reset ? tb_ts + 12'd1 : 12'd0;
    end
  end

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] cnt(input int ch);
    return channel_data_counter[ch*CNT_W +: CNT_W];
  endfunction

  function automatic logic [15:0] drops(input int ch);
    return ch_drop_cnt[ch*16 +: 16];
  endfunction

  function automatic int queued();
    int n = 0;
    for (int i = 0; i < NUM_CH; i++) n += exp_q[i].size();
    return n;
  endfunction

  task automatic push_exp(input int ch, input logic [DATA_W-1:0] d);
    exp_q[ch].push_back(d);
`ifdef CH_TIMESTAMP_EN
    ts_q[ch].push_back(-1);
`endif
  endtask

  task automatic flush_exp();
    for (int i = 0; i < NUM_CH; i++) begin
      exp_q[i].delete();
`ifdef CH_TIMESTAMP_EN
      ts_q[i].delete();
`endif
    end
    exp_ch.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk160);
      #1;
    end
  endtask

  // Lane i carries base+i; only lanes in accept are expected to reach the output.
  task automatic apply_stimulus(input logic [NUM_CH-1:0] mask, input logic [NUM_CH-1:0] accept,
                                input logic [DATA_W-1:0] base);
    ch_valid = mask;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_data[i*DATA_W +: DATA_W] = base + DATA_W'(i);
      if (accept[i]) push_exp(i, base + DATA_W'(i));
    end
    tick(1);
    ch_valid = '0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (queued() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    check_output("drain_left", queued(), 0);
  endtask

  // Monitor: pops expectations on every accepted transfer and checks stability under stall.
  initial begin
    logic              stall_prev;
    logic [DATA_W-1:0] data_prev;
    logic [ID_W-1:0]   ch_prev;
    logic [DATA_W-1:0] d;
    stall_prev = 1'b0;
    data_prev  = '0;
    ch_prev    = '0;
    forever begin
      @(negedge clk160);
      if (reset) begin
        if (stall_prev) begin
          check_output("hold_valid", out_valid, 1'b1);
          check_output("hold_data", out_data, data_prev);
          check_output("hold_ch", out_ch, ch_prev);
        end
        if (out_valid && out_ready) begin
          if (exp_q[out_ch].size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_frame: got ch %0d data %0h expected none", out_ch, out_data);
          end else begin
            d = exp_q[out_ch].pop_front();
            check_output("stream_data", out_data, d);
`ifdef CH_TIMESTAMP_EN
            begin
              int t;
              t = ts_q[out_ch].pop_front();
              if (t >= 0) check_output("stream_ts", out_ts, t);
            end
`endif
          end
          if (exp_ch.size() != 0) check_output("rr_order", out_ch, exp_ch.pop_front());
        end
        stall_prev = out_valid && !out_ready;
        data_prev  = out_data;
        ch_prev    = out_ch;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [3:0]        rdy_pat;
    logic [DATA_W-1:0] d;
    int                ch;
    int                sent;
    int                n;

    reset = 1'b0; enable = '1; tds_mode = 1'b1; strip_linked = '1; pad_linked = '1;
    ch_valid = '0; ch_data = '0; channel_fifo_s_reset = '0; data_tran_stop = '0; out_ready = 1'b0;
    tick(4);
    check_output("rst_valid", out_valid, 1'b0);
    check_output("rst_empty", channel_fifo_empty, 4'hF);
    check_output("rst_count", channel_data_counter, '0);
    check_output("rst_out_ch", out_ch, '0);
    check_output("rst_out_data", out_data, '0);
    check_output("rst_ovf", ch_overflow, '0);
    check_output("rst_drops", ch_drop_cnt, '0);
    check_output("linked_strip", channel_linked, 4'hF);
    reset = 1'b1;
    tick(2);

    $display("[TB] single frame latency");
    out_ready = 1'b1;
    ch_data = '0;
    ch_data[2*DATA_W +: DATA_W] = 120'h1234;
    ch_valid = 4'b0100;
    push_exp(2, 120'h1234);
    tick(1);
    ch_valid = '0;
    check_output("lat_t0_valid", out_valid, 1'b0);
    check_output("lat_t0_cnt2", cnt(2), 1);
    tick(1);
    check_output("lat_t1_valid", out_valid, 1'b0);
    check_output("lat_t1_cnt2", cnt(2), 1);
    tick(1);
    check_output("lat_t2_valid", out_valid, 1'b1);
    check_output("lat_t2_ch", out_ch, 2);
    check_output("lat_t2_data", out_data, 120'h1234);
    check_output("lat_t2_cnt2", cnt(2), 0);
    tick(3);
    check_output("lat_drained", queued(), 0);

    $display("[TB] round robin");
    reset = 1'b0;
    tick(2);
    flush_exp();
    reset = 1'b1;
    out_ready = 1'b0;
    apply_stimulus(4'b0001, 4'b0001, 120'hA00);
    apply_stimulus(4'b1111, 4'b1111, 120'hB00);
    apply_stimulus(4'b1111, 4'b1111, 120'hC00);
    apply_stimulus(4'b1110, 4'b1110, 120'hD00);
    tick(4);
    check_output("rr_pre_cnt0", cnt(0), 2);
    check_output("rr_pre_cnt3", cnt(3), 3);
    check_output("rr_pre_ch", out_ch, 0);
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < NUM_CH; c++) exp_ch.push_back(ID_W'(c));
    end
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk160);
      check_output("rr_no_bubble", out_valid, 1'b1);
    end
    tick(1);
    wait_drain(50);
    check_output("rr_order_left", exp_ch.size(), 0);

    $display("[TB] overflow and soft reset");
    out_ready = 1'b0;
    apply_stimulus(4'b0001, 4'b0001, 120'hE00);
    tick(3);
    for (int k = 0; k < 20; k++) apply_stimulus(4'b0010, 4'b0000, 120'h100 + DATA_W'(k));
    tick(1);
    check_output("ovf_cnt1", cnt(1), 16);
    check_output("ovf_flags", ch_overflow, 4'b0010);
    check_output("ovf_drops1", drops(1), 4);
    check_output("ovf_empty1", channel_fifo_empty[1], 1'b0);
    channel_fifo_s_reset = 4'b0010;
    tick(1);
    channel_fifo_s_reset = '0;
    check_output("srst_cnt1", cnt(1), 0);
    check_output("srst_ovf", ch_overflow, 4'b0000);
    check_output("srst_drops1", drops(1), 0);
    check_output("srst_empty1", channel_fifo_empty[1], 1'b1);
    check_output("srst_out_ch", out_ch, 0);
    out_ready = 1'b1;
    wait_drain(20);

    $display("[TB] gating");
    out_ready = 1'b0;
    tds_mode = 1'b0;
    pad_linked = 4'b0111;
    tick(1);
    check_output("linked_pad", channel_linked, 4'b0111);
    apply_stimulus(4'b1000, 4'b0000, 120'hF00);
    apply_stimulus(4'b0001, 4'b0001, 120'h100);
    apply_stimulus(4'b0001, 4'b0001, 120'h200);
    apply_stimulus(4'b0001, 4'b0001, 120'h300);
    tick(3);
    check_output("gate_cnt3", cnt(3), 0);
    check_output("gate_cnt0", cnt(0), 2);
    data_tran_stop = 4'b0001;
    apply_stimulus(4'b0001, 4'b0000, 120'h400);
    tick(1);
    check_output("stop_cnt0", cnt(0), 2);
    out_ready = 1'b1;
    wait_drain(20);
    tick(2);
    check_output("stop_drained_empty", channel_fifo_empty, 4'hF);
    data_tran_stop = '0;
    tds_mode = 1'b1;
    pad_linked = '1;

    $display("[TB] backpressure stream");
    rdy_pat = 4'b1001;
    sent = 0;
    for (int cyc = 0; cyc < 3100; cyc++) begin
      out_ready = rdy_pat[cyc % 4];
      if (cyc % 3 == 0 && sent < 1000) begin
        ch = int'($urandom_range(0, NUM_CH - 1));
        d = DATA_W'({$urandom, $urandom, $urandom, $urandom});
        ch_valid = '0;
        ch_valid[ch] = 1'b1;
        ch_data[ch*DATA_W +: DATA_W] = d;
        push_exp(ch, d);
        sent++;
      end else begin
        ch_valid = '0;
      end
      tick(1);
    end
    ch_valid = '0;
    out_ready = 1'b1;
    wait_drain(200);
    check_output("bp_no_ovf", ch_overflow, '0);

`ifdef CH_TIMESTAMP_EN
    $display("[TB] timestamp wrap");
    for (int rep = 0; rep < 2; rep++) begin
      n = 0;
      while (tb_ts != 12'd4094 && n < 5000) begin
        tick(1);
        n++;
      end
      check_output("ts_wait", tb_ts, 12'd4094);
      ch_data[0 +: DATA_W] = 120'h7E0 + DATA_W'(rep);
      ch_valid = 4'b0001;
      exp_q[0].push_back(120'h7E0 + DATA_W'(rep));
      ts_q[0].push_back(4094);
      tick(1);
      ch_valid = '0;
    end
    wait_drain(20);
`endif

    $display("[TB] reset mid-stream");
    out_ready = 1'b0;
    apply_stimulus(4'b1111, 4'b1111, 120'h500);
    apply_stimulus(4'b1111, 4'b1111, 120'h600);
    tick(3);
    check_output("mid_pre_valid", out_valid, 1'b1);
    reset = 1'b0;
    tick(1);
    check_output("mid_valid", out_valid, 1'b0);
    check_output("mid_count", channel_data_counter, '0);
    check_output("mid_empty", channel_fifo_empty, 4'hF);
    check_output("mid_out_data", out_data, '0);
    flush_exp();
    reset = 1'b1;
    out_ready = 1'b1;
    tick(5);
    check_output("post_rst_valid", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tds_channel_merger.md
Name: tds_channel_merger

Overview:
- Parametrised N-channel successor to the 4-channel TDS data logger front-end.
- Accepts decoded 120-bit strip/pad frames from NUM_CH deserialiser/decoder lanes already retimed to clk160, and buffers each lane in its own FIFO.
- Merges the lanes through a round-robin arbiter into a single channel-tagged valid/ready stream for the readout/UDP packer.
- Adds per-channel overflow tracking and drop counting.

Parameters:
- NUM_CH, 4, number of input channels (1..16).
- DATA_W, 120, frame width in bits.
- FIFO_DEPTH, 512, words per channel FIFO; must be a power of 2.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of the occupancy counter (derived; do not override).
- ID_W, $clog2(NUM_CH) with a minimum of 1, width of the channel tag (derived).

Ports:
- clk160  in  1  single clock for all logic.
- reset  in  1  synchronous, active-low.
- enable  in  NUM_CH  per-channel capture enable.
- tds_mode  in  1  1 = strip, 0 = pad.
- strip_linked  in  NUM_CH  decoder strip lock.
- pad_linked  in  NUM_CH  decoder pad lock.
- ch_valid  in  NUM_CH  per-channel frame strobe, 1 cycle per frame.
- ch_data  in  NUM_CH*DATA_W  frames; channel i occupies bits [i*DATA_W +: DATA_W].
- channel_fifo_s_reset  in  NUM_CH  per-channel soft clear, active-high.
- data_tran_stop  in  NUM_CH  per-channel write inhibit.
- channel_linked  out  NUM_CH  = tds_mode ? strip_linked : pad_linked (combinational).
- out_valid  out  1  merged stream valid.
- out_ready  in  1  merged stream ready.
- out_data  out  DATA_W  merged frame.
- out_ch  out  ID_W  source channel of out_data.
- channel_data_counter  out  NUM_CH*CNT_W  per-channel FIFO occupancy.
- channel_fifo_empty  out  NUM_CH  occupancy == 0.
- ch_overflow  out  NUM_CH  sticky flag: a frame was dropped because the FIFO was full.
- ch_drop_cnt  out  NUM_CH*16  saturating count of dropped frames.

Behaviour:
- Reset (reset == 0 at a clk160 edge):
  - All pointers, counters, ch_overflow, ch_drop_cnt, out_valid and the arbiter pointer go to 0.
  - channel_fifo_empty goes to all-1; out_data and out_ch go to 0.
  - Reset applies mid-transfer with no drain; in-flight frames are lost.
- Write qualification for channel i: wr_i = ch_valid[i] & enable[i] & channel_linked[i] & ~data_tran_stop[i] & ~channel_fifo_s_reset[i].
- Full FIFO (count == FIFO_DEPTH) with wr_i asserted:
  - The frame is discarded and ch_overflow[i] is set.
  - ch_drop_cnt[i] increments, saturating at 0xFFFF.
- Occupancy update:
  - Counter updates on the edge after a write or pop.
  - A write and a pop on the same channel in the same cycle leave the count unchanged.
  - A write into a full FIFO that is popped in the same cycle is accepted.
- Pointers wrap modulo FIFO_DEPTH.
- Output register and arbiter:
  - Single output register stage. "Load allowed" = (~out_valid | out_ready).
  - When load is allowed and any FIFO is non-empty, the arbiter grants the first non-empty channel searching upward from (last_grant+1) mod NUM_CH.
  - The granted head word is popped; out_data/out_ch load on that edge, out_valid = 1, and last_grant is updated.
  - When load is allowed and all FIFOs are empty, out_valid goes to 0.
  - While out_valid & ~out_ready, out_data and out_ch are held stable and no pop occurs.
- Latency:
  - Frame on ch_valid at edge t is written at t.
  - channel_data_counter reflects it after t.
  - Earliest out_valid is at edge t+2 (FIFO memory read registered, then output register).
  - Sustained throughput is 1 frame per cycle aggregated across all channels.
- channel_fifo_s_reset[i]:
  - Clears channel i's pointers, count, ch_overflow[i] and ch_drop_cnt[i] on the next edge.
  - A word from channel i already in the output register is unaffected.
  - A pop granted in the same cycle is suppressed; the arbiter skips channel i that cycle.
- enable, channel_linked and data_tran_stop gate writes only; buffered data still drains.
- The FIFOs are inferred block RAM, one per channel.

Optional Feature:
- Macro: CH_TIMESTAMP_EN.
- Defined:
  - A free-running 12-bit counter ts_cnt (reset to 0, wraps 4095 to 0) is captured with every accepted write and stored alongside the frame.
  - Extra output port out_ts [11:0] is aligned with out_data and loaded at the same edge.
  - FIFO word width becomes DATA_W+12.
- Undefined: no counter, no out_ts port, FIFO width DATA_W.

Test Plan:
- Reset then single frame: reset low 4 cycles then high; NUM_CH=4, all enabled/linked, tds_mode=1; one ch_valid[2] with data 120'h1234 at edge t, out_ready=1 -> out_valid at t+2, out_data=120'h1234, out_ch=2; counter[2] reads 1 then 0.
- Round-robin: preload 3 frames in each of ch0..ch3 with out_ready=0, then out_ready=1 -> out_ch sequence 0,1,2,3,0,1,2,3,0,1,2,3 with no bubbles.
- Backpressure: out_ready toggles 1,0,0,1 -> out_data/out_ch unchanged while out_valid & ~out_ready; no frame lost or duplicated (scoreboard over 1000 random frames).
- Overflow: FIFO_DEPTH=16, out_ready=0, 20 writes to ch1 -> counter[1]=16, ch_overflow[1]=1, ch_drop_cnt[1]=4; channel_fifo_s_reset[1] pulse -> counter 0, overflow 0, drop_cnt 0, channel_fifo_empty[1]=1.
- Gating: tds_mode=0 with pad_linked[3]=0, strip_linked[3]=1 -> channel_linked[3]=0 and ch3 writes ignored; data_tran_stop[0]=1 -> ch0 count frozen, existing ch0 data still drains.
- CH_TIMESTAMP_EN: write at ts_cnt=4094 and at 4096 edges later -> out_ts=4094 for both; reset mid-stream -> out_valid=0 and all counters 0 on the next edge.
